// File: rtl/four_request_capture_pkg.sv
// Shared definitions for the four-channel request capture block.
package four_request_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 8;

  localparam int unsigned IDX_D = 3;
  localparam int unsigned IDX_C = 2;
  localparam int unsigned IDX_B = 1;
  localparam int unsigned IDX_A = 0;

  // One-hot mask of the highest-priority set bit (d over c over b over a).
  function automatic logic [3:0] top_bit_mask(input logic [3:0] v);
    logic [3:0] m;
    m = '0;
    if (v[IDX_D])      m[IDX_D] = 1'b1;
    else if (v[IDX_C]) m[IDX_C] = 1'b1;
    else if (v[IDX_B]) m[IDX_B] = 1'b1;
    else if (v[IDX_A]) m[IDX_A] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/four_request_capture_debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw request line.
// rise_o pulses for one cycle on the edge after the debounced level goes 0->1.
module request_debounce
  import four_request_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; adopt the synchronized level on the last one.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST_CNT) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer, debounced level, counter and rise pulse registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/four_request_capture.sv
// Captures debounced rising edges on four request lines and presents them,
// highest priority first, as a frozen snapshot to a downstream 4:2 encoder.
module four_request_capture
  import four_request_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic req_c,
  input  logic req_d,
  input  logic ack,
  output logic pend_a,
  output logic pend_b,
  output logic pend_c,
  output logic pend_d,
  output logic valid
);

  logic [3:0] rise;
  logic [3:0] pending_q, pending_d;
  logic [3:0] snap_q, snap_d;
  logic [3:0] clr;
  logic [3:0] pend_q, pend_d_out;
  logic       valid_q, valid_d;
  state_e     state_q, state_d;

  request_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk_i(clk), .reset_i(reset), .req_i(req_a), .rise_o(rise[IDX_A]));
  request_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk_i(clk), .reset_i(reset), .req_i(req_b), .rise_o(rise[IDX_B]));
  request_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
    .clk_i(clk), .reset_i(reset), .req_i(req_c), .rise_o(rise[IDX_C]));
  request_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
    .clk_i(clk), .reset_i(reset), .req_i(req_d), .rise_o(rise[IDX_D]));

  // State, pending, snapshot and registered output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      snap_q    <= '0;
      valid_q   <= 1'b0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d_out;
    end
  end

  // Next state; a new rise is OR-ed in after the ack clear so a colliding set survives.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          snap_d  = pending_q;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          clr     = top_bit_mask(snap_q);
          snap_d  = snap_q & ~clr;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q & ~clr) | rise;
  end

  // Outputs are registered from next-state so they change on the same edge as the FSM.
  always_comb begin
    valid_d    = (state_d == PRESENT);
    pend_d_out = valid_d ? snap_d : '0;
  end

  assign valid  = valid_q;
  assign pend_a = pend_q[IDX_A];
  assign pend_b = pend_q[IDX_B];
  assign pend_c = pend_q[IDX_C];
  assign pend_d = pend_q[IDX_D];

endmodule

// File: tb/tb_four_request_capture.sv
// Directed and randomized bench for four_request_capture with a behavioural model.
module tb_four_request_capture;

  localparam int unsigned D = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0, req_c = 1'b0, req_d = 1'b0;
  logic ack   = 1'b0;
  logic pend_a, pend_b, pend_c, pend_d, valid;

  int checks = 0;
  int errors = 0;

  // Model state: raw/synchronized sample histories, debounced levels,
  // pending event set, snapshot and a presentation phase (0 idle, 1 present, 2 gap).
  bit [3:0] raw_hist[$];
  bit [3:0] samp_hist[$];
  bit [3:0] m_deb, m_rise, m_pending, m_snap;
  int       m_phase;

  always #5 clk = ~clk;

  four_request_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .ack(ack),
    .pend_a(pend_a), .pend_b(pend_b), .pend_c(pend_c), .pend_d(pend_d),
    .valid(valid)
  );

  function automatic logic [3:0] dut_pend();
    return {pend_d, pend_c, pend_b, pend_a};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit [3:0] clr, samp, rise_now;
    bit found, all_diff;
    if (reset) begin
      raw_hist.delete();
      samp_hist.delete();
      m_deb = '0; m_rise = '0; m_pending = '0; m_snap = '0; m_phase = 0;
      return;
    end
    clr = '0;
    case (m_phase)
      0: if (m_pending != 0) begin m_snap = m_pending; m_phase = 1; end
      1: if (ack) begin
           found = 0;
           for (int i = 3; i >= 0; i--)
             if (!found && m_snap[i]) begin clr[i] = 1'b1; found = 1; end
           m_snap    = m_snap & ~clr;
           m_pending = m_pending & ~clr;
           m_phase   = 2;
         end
      default: m_phase = 0;
    endcase
    m_pending = m_pending | m_rise;
    // The debouncer at this edge sees the raw value sampled two edges earlier.
    samp = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 4'b0;
    raw_hist.push_back({req_d, req_c, req_b, req_a});
    samp_hist.push_back(samp);
    if (raw_hist.size() > 64) void'(raw_hist.pop_front());
    if (samp_hist.size() > 64) void'(samp_hist.pop_front());
    rise_now = '0;
    for (int ch = 0; ch < 4; ch++) begin
      if (samp_hist.size() >= D) begin
        all_diff = 1;
        for (int k = 0; k < int'(D); k++)
          if (samp_hist[samp_hist.size() - 1 - k][ch] == m_deb[ch]) all_diff = 0;
        if (all_diff) begin
          m_deb[ch]    = ~m_deb[ch];
          rise_now[ch] = m_deb[ch];
        end
      end
    end
    m_rise = rise_now;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_valid", {3'b0, valid}, {3'b0, (m_phase == 1)});
    chk("model_pend", dut_pend(), (m_phase == 1) ? m_snap : 4'b0);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    checks++;
    assert (valid === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout observed=%b expected=1", tag, valid);
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  int hold[4];
  bit [3:0] rnd;

  initial begin
    // Reset state
    reset = 1'b1;
    steps(2);
    chk("reset_valid", {3'b0, valid}, 4'd0);
    chk("reset_pend", dut_pend(), 4'b0000);
    reset = 1'b0;

    // Clean single request and latency
    req_c = 1'b1;
    repeat (7) begin
      step();
      chk("latency_early_valid", {3'b0, valid}, 4'd0);
    end
    step();
    chk("latency_valid", {3'b0, valid}, 4'd1);
    chk("single_pend", dut_pend(), 4'b0100);
    ack_pulse();
    chk("gap_valid", {3'b0, valid}, 4'd0);
    chk("gap_pend", dut_pend(), 4'b0000);
    step();
    chk("idle_valid", {3'b0, valid}, 4'd0);
    steps(5);
    req_c = 1'b0;
    steps(8);

    // Bounce rejection
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) req_b = ~req_b;
      step();
      chk("bounce_valid", {3'b0, valid}, 4'd0);
    end
    req_b = 1'b0;
    repeat (10) begin
      step();
      chk("bounce_quiet_pend", dut_pend(), 4'b0000);
    end

    // Priority ordering
    req_a = 1'b1; req_b = 1'b1; req_d = 1'b1;
    wait_valid("prio1");
    chk("prio_snap1", dut_pend(), 4'b1011);
    ack_pulse();
    wait_valid("prio2");
    chk("prio_snap2", dut_pend(), 4'b0011);
    ack_pulse();
    wait_valid("prio3");
    chk("prio_snap3", dut_pend(), 4'b0001);
    ack_pulse();
    repeat (10) begin
      step();
      chk("prio_drained_valid", {3'b0, valid}, 4'd0);
    end
    req_a = 1'b0; req_b = 1'b0; req_d = 1'b0;
    steps(8);

    // Accumulation during PRESENT
    req_a = 1'b1;
    wait_valid("accum1");
    chk("accum_snap1", dut_pend(), 4'b0001);
    req_c = 1'b1;
    repeat (12) begin
      step();
      chk("accum_frozen", dut_pend(), 4'b0001);
    end
    ack_pulse();
    wait_valid("accum2");
    chk("accum_snap2", dut_pend(), 4'b0100);
    ack_pulse();
    steps(3);
    req_a = 1'b0; req_c = 1'b0;
    steps(8);

    // Set/clear collision on d
    req_d = 1'b1;
    wait_valid("coll1");
    chk("coll_snap1", dut_pend(), 4'b1000);
    req_d = 1'b0;
    steps(8);
    req_d = 1'b1;
    steps(6);
    ack_pulse();
    wait_valid("coll2");
    chk("coll_snap2", dut_pend(), 4'b1000);
    ack_pulse();
    steps(3);
    req_d = 1'b0;
    steps(8);

    // Reset mid-operation
    req_c = 1'b1; req_d = 1'b1;
    wait_valid("rst1");
    chk("rst_snap", dut_pend(), 4'b1100);
    req_c = 1'b0; req_d = 1'b0;
    reset = 1'b1;
    step();
    chk("rst_mid_valid", {3'b0, valid}, 4'd0);
    chk("rst_mid_pend", dut_pend(), 4'b0000);
    reset = 1'b0;
    repeat (15) begin
      step();
      chk("rst_after_valid", {3'b0, valid}, 4'd0);
    end

    // Input held high through reset is a fresh edge afterwards
    req_a = 1'b1;
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    wait_valid("held");
    chk("held_snap", dut_pend(), 4'b0001);
    ack_pulse();
    steps(3);
    req_a = 1'b0;
    steps(8);

    // Randomized traffic against the model
    for (int ch = 0; ch < 4; ch++) hold[ch] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rnd = {req_d, req_c, req_b, req_a};
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] == 0) begin
          rnd[ch]  = 1'($urandom_range(0, 1));
          hold[ch] = int'($urandom_range(1, 14));
        end else begin
          hold[ch]--;
        end
      end
      {req_d, req_c, req_b, req_a} = rnd;
      ack = ($urandom_range(0, 2) == 0);
      step();
    end
    ack = 1'b0;
    steps(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_request_capture.md
FOUR_REQUEST_CAPTURE -- requirements
Module: four_request_capture

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, legal range 1..255, giving the consecutive stable cycles needed before a debounced level changes.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports req_a, req_b, req_c, req_d, input, 1 bit each: asynchronous raw request lines from switches or buttons; req_d has the highest priority and req_a the lowest.
REQ-005 The block SHALL have port ack, input, 1 bit: a single-cycle pulse from the consumer stating that the presented highest-priority request has been served.
REQ-006 The block SHALL have ports pend_a, pend_b, pend_c, pend_d, output, 1 bit each: registered, frozen request snapshot that drives the a, b, c, d inputs of the downstream 4:2 priority encoder.
REQ-007 The block SHALL have port valid, output, 1 bit: high while the snapshot is being presented and the encoder code is meaningful.

Function
REQ-008 Each req_x SHALL pass through a 2-flip-flop synchronizer; the synchronized level first reflects an input change after the 2nd clock edge.
REQ-009 Debounce counter:
- Each channel SHALL keep an 8-bit counter.
- The counter clears on every cycle where the synchronized level equals the debounced level.
- On the DEBOUNCE_CYCLES-th consecutive differing cycle, the debounced level takes the synchronized value and the counter clears.
REQ-010 A 0->1 transition of a debounced level SHALL set that channel's pending bit on the next edge. 1->0 transitions SHALL have no effect.
REQ-011 The FSM SHALL have three states: IDLE, PRESENT and GAP.
REQ-012 IDLE:
- If any pending bit is set, the FSM SHALL load snapshot <= pending and go to PRESENT.
- Otherwise it SHALL stay in IDLE.
REQ-013 PRESENT:
- valid SHALL be 1, and pend_x SHALL equal the snapshot, held constant.
- On ack, the FSM SHALL clear the highest-priority set bit in both the snapshot and the pending register, then go to GAP.
REQ-014 GAP SHALL last exactly one cycle with valid=0, then go to IDLE, so the consumer sees a valid deassertion between codes.
REQ-015 In IDLE and GAP, valid SHALL be 0 and pend_x SHALL be 0.
REQ-016 ack outside PRESENT SHALL be ignored. ack held high for several cycles SHALL clear only one bit per PRESENT visit.
REQ-017 If a new rising edge sets a pending bit in the same cycle that ack clears that bit, the set SHALL win and the event is kept.
REQ-018 Edges arriving during PRESENT or GAP SHALL accumulate in pending only; they SHALL appear in the next snapshot and SHALL NOT modify the current one.
REQ-019 A repeated edge on a bit that is already pending SHALL merge into it and SHALL NOT be counted twice.
REQ-020 Latency from req_x rising (stable) to valid high SHALL be DEBOUNCE_CYCLES+4 edges; with the default of 4, valid rises after the 8th edge.

Reset
REQ-021 On reset=1 at a clock edge, the following SHALL clear to 0 and the FSM SHALL enter IDLE:
- synchronizers, debounced levels and counters;
- pending and snapshot registers;
- valid and pend_a..pend_d.
REQ-022 Reset asserted during PRESENT SHALL drop valid and all pend_x on that same edge and discard all queued events.
REQ-023 After reset release, an input already held high SHALL be treated as a fresh rising edge once debounced, because the debounced level restarts at 0.

Structure
REQ-024 A shared package of localparams SHALL hold:
- the FSM state encodings (IDLE=2'd0, PRESENT=2'd1, GAP=2'd2);
- the debounce counter width (8);
- the channel priority indices (d=3, c=2, b=1, a=0).
REQ-025 The synchronizer and debounce logic SHALL be one sub-module, request_debounce, instantiated four times. The pending register, snapshot register and FSM SHALL reside in four_request_capture.

Verification
REQ-026 Clean single request: reset, then raise req_c and hold it, DEBOUNCE_CYCLES=4 -> after edge 8, valid=1 and pend={d,c,b,a}=0100; pulse ack -> next cycle valid=0 (GAP), then IDLE with valid=0.
REQ-027 Bounce rejection: toggle req_b every 2 cycles for 20 cycles, then hold it low -> valid never asserts and pending stays 0000.
REQ-028 Priority ordering: raise req_a, req_b and req_d in the same cycle -> snapshot 1011; successive acks present 0011, then 0001, then valid stays 0.
REQ-029 Accumulation: in PRESENT with snapshot 0001, raise req_c -> pend outputs stay 0001 until ack; the next PRESENT shows 0100.
REQ-030 Set/clear collision: arrange for req_d's pending-set edge to coincide with an ack that clears d -> the next snapshot still has d=1.
REQ-031 Reset mid-operation: assert reset during PRESENT with snapshot 1100 -> on that edge valid=0 and pend=0000; after release with inputs held low, valid stays 0.
